// File: rtl/cnn_layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cnn_layer_sequencer_if
// Brief    : Control bundle between the inference sequencer, the top-level
//            start/done client and the four stage engines.
// Revision : 1.0  initial release
// ============================================================================
interface cnn_layer_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [3:0]       label;
    logic             clear_stats;
    logic             conv_start;
    logic             conv_done;
    logic             pool_start;
    logic             pool_done;
    logic             fc_start;
    logic             fc_done;
    logic             argmax_start;
    logic             argmax_done;
    logic [3:0]       argmax_class;
    logic             busy;
    logic             done;
    logic [3:0]       classification;
    logic             correct;
    logic             timeout;
    logic [CNT_W-1:0] img_count;
    logic [CNT_W-1:0] correct_count;

    modport slave (
        input  start, label, clear_stats,
        input  conv_done, pool_done, fc_done, argmax_done, argmax_class,
        output conv_start, pool_start, fc_start, argmax_start,
        output busy, done, classification, correct, timeout,
        output img_count, correct_count
    );

    modport master (
        output start, label, clear_stats,
        output conv_done, pool_done, fc_done, argmax_done, argmax_class,
        input  conv_start, pool_start, fc_start, argmax_start,
        input  busy, done, classification, correct, timeout,
        input  img_count, correct_count
    );
endinterface
`default_nettype wire

// File: rtl/cnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cnn_layer_sequencer
// Brief    : Sequences conv -> pool -> fc -> argmax for one image, with a
//            per-stage watchdog and running accuracy statistics.
// Revision : 1.0  initial release
// ============================================================================
module cnn_layer_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cnn_layer_sequencer_if.slave  seq_if
);
    localparam int             CW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  c_TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONV   = 3'd1,
        S_POOL   = 3'd2,
        S_FC     = 3'd3,
        S_ARGMAX = 3'd4
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    stage_cnt_q;
    logic [3:0]       label_q;
    logic [3:0]       class_q;
    logic             correct_q;
    logic             timeout_q;
    logic             done_q;
    logic             conv_start_q;
    logic             pool_start_q;
    logic             fc_start_q;
    logic             argmax_start_q;
    logic [CNT_W-1:0] img_q;
    logic [CNT_W-1:0] corr_q;
    logic             w_stage_done;

    always_comb begin
        w_stage_done = 1'b0;
        case (state_q)
            S_CONV:   w_stage_done = seq_if.conv_done;
            S_POOL:   w_stage_done = seq_if.pool_done;
            S_FC:     w_stage_done = seq_if.fc_done;
            S_ARGMAX: w_stage_done = seq_if.argmax_done;
            default:  w_stage_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            stage_cnt_q    <= '0;
            label_q        <= 4'h0;
            class_q        <= 4'h0;
            correct_q      <= 1'b0;
            timeout_q      <= 1'b0;
            done_q         <= 1'b0;
            conv_start_q   <= 1'b0;
            pool_start_q   <= 1'b0;
            fc_start_q     <= 1'b0;
            argmax_start_q <= 1'b0;
        end else begin
            conv_start_q   <= 1'b0;
            pool_start_q   <= 1'b0;
            fc_start_q     <= 1'b0;
            argmax_start_q <= 1'b0;
            done_q         <= 1'b0;
            stage_cnt_q    <= stage_cnt_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (seq_if.start) begin
                        label_q      <= seq_if.label;
                        state_q      <= S_CONV;
                        conv_start_q <= 1'b1;
                        stage_cnt_q  <= '0;
                    end
                end
                default: begin
                    // A done in the watchdog's last cycle takes priority over the abort
                    if (w_stage_done) begin
                        stage_cnt_q <= '0;
                        case (state_q)
                            S_CONV: begin
                                state_q      <= S_POOL;
                                pool_start_q <= 1'b1;
                            end
                            S_POOL: begin
                                state_q    <= S_FC;
                                fc_start_q <= 1'b1;
                            end
                            S_FC: begin
                                state_q        <= S_ARGMAX;
                                argmax_start_q <= 1'b1;
                            end
                            S_ARGMAX: begin
                                state_q   <= S_IDLE;
                                done_q    <= 1'b1;
                                class_q   <= seq_if.argmax_class;
                                correct_q <= (seq_if.argmax_class == label_q);
                                timeout_q <= 1'b0;
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end else if (stage_cnt_q == c_TO_LAST) begin
                        state_q   <= S_IDLE;
                        done_q    <= 1'b1;
                        class_q   <= 4'hF;
                        correct_q <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Statistics follow the done pulse; a coincident clear_stats wins.
    always_ff @(posedge clk) begin
        if (rst || seq_if.clear_stats) begin
            img_q  <= '0;
            corr_q <= '0;
        end else if (done_q) begin
            if (img_q != '1) begin
                img_q <= img_q + 1'b1;
            end
            if (correct_q && (corr_q != '1)) begin
                corr_q <= corr_q + 1'b1;
            end
        end
    end

    assign seq_if.conv_start     = conv_start_q;
    assign seq_if.pool_start     = pool_start_q;
    assign seq_if.fc_start       = fc_start_q;
    assign seq_if.argmax_start   = argmax_start_q;
    assign seq_if.busy           = (state_q != S_IDLE);
    assign seq_if.done           = done_q;
    assign seq_if.classification = class_q;
    assign seq_if.correct        = correct_q;
    assign seq_if.timeout        = timeout_q;
    assign seq_if.img_count      = img_q;
    assign seq_if.correct_count  = corr_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_layer_sequencer
// Brief    : Scoreboard bench for cnn_layer_sequencer with modelled stage engines.
// Revision : 1.0  initial release
// ============================================================================
module tb_cnn_layer_sequencer;
    localparam int TO = 16;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnn_layer_sequencer_if #(.CNT_W(CW)) bus ();

    cnn_layer_sequencer #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .seq_if (bus)
    );

    typedef struct {
        int         cyc;
        logic [3:0] cls;
        logic       corr;
        logic       tmo;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   resp_delay = 0;
    bit   tie_high   = 1'b0;
    bit   stall_pool = 1'b0;
    bit   force_fc   = 1'b0;
    int   start_cnt[4];
    int   start_cyc[4];
    int   rcnt[4];
    bit   armed[4];

    always @(posedge clk) cyc = cyc + 1;

    // Stage engine model: each done comes resp_delay cycles after its start pulse.
    always @(posedge clk) begin
        logic [3:0] st;
        logic [3:0] dn;
        #2;
        st = {bus.argmax_start, bus.fc_start, bus.pool_start, bus.conv_start};
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                armed[i] = 1'b0;
                rcnt[i]  = 0;
            end else if (st[i]) begin
                armed[i] = 1'b1;
                rcnt[i]  = resp_delay;
            end else if (armed[i]) begin
                if (rcnt[i] == 0) armed[i] = 1'b0;
                else rcnt[i] = rcnt[i] - 1;
            end
            dn[i] = tie_high | (armed[i] && (rcnt[i] == 0));
        end
        if (stall_pool) dn[1] = 1'b0;
        bus.conv_done   = dn[0];
        bus.pool_done   = dn[1];
        bus.fc_done     = dn[2] | force_fc;
        bus.argmax_done = dn[3];
    end

    always @(negedge clk) begin
        logic [3:0] st;
        exp_t e;
        st = {bus.argmax_start, bus.fc_start, bus.pool_start, bus.conv_start};
        for (int i = 0; i < 4; i++) begin
            if (st[i] === 1'b1) begin
                start_cnt[i] = start_cnt[i] + 1;
                start_cyc[i] = cyc;
            end
        end
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: cycle=%0d got done=1 want no pending result", cyc);
            end else begin
                e = sb.pop_front();
                total++;
                if (cyc !== e.cyc) begin
                    bad++; $display("FAIL done_cycle: got %0d want %0d", cyc, e.cyc);
                end
                total++;
                if (bus.classification !== e.cls) begin
                    bad++; $display("FAIL classification: got %h want %h", bus.classification, e.cls);
                end
                total++;
                if (bus.correct !== e.corr) begin
                    bad++; $display("FAIL correct: got %b want %b", bus.correct, e.corr);
                end
                total++;
                if (bus.timeout !== e.tmo) begin
                    bad++; $display("FAIL timeout: got %b want %b", bus.timeout, e.tmo);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_starts();
        for (int i = 0; i < 4; i++) begin
            start_cnt[i] = 0;
            start_cyc[i] = -1;
        end
    endtask

    task automatic issue_start(input logic [3:0] lbl, input logic [3:0] cls, input int lat, input bit tmo);
        exp_t e;
        bus.label        = lbl;
        bus.argmax_class = cls;
        e.cyc  = cyc + lat;
        e.cls  = tmo ? 4'hF : cls;
        e.corr = !tmo && (cls == lbl);
        e.tmo  = tmo;
        sb.push_back(e);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (((sb.size() != 0) || (bus.busy !== 1'b0)) && (n < budget)) begin
            step();
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL wait_idle: still busy after %0d cycles, pending=%0d", budget, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sb.delete();
        step();
        step();
        @(negedge clk);
        total++;
        if ({bus.conv_start, bus.pool_start, bus.fc_start, bus.argmax_start, bus.busy, bus.done} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 000000",
                {bus.conv_start, bus.pool_start, bus.fc_start, bus.argmax_start, bus.busy, bus.done});
        end
        total++;
        if ({bus.classification, bus.correct, bus.timeout} !== 6'b0) begin
            bad++; $display("FAIL reset_result: got %h/%b/%b want 0/0/0", bus.classification, bus.correct, bus.timeout);
        end
        total++;
        if ({bus.img_count, bus.correct_count} !== '0) begin
            bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", bus.img_count, bus.correct_count);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_nominal();
        int k;
        resp_delay = 2;
        clr_starts();
        k = cyc;
        issue_start(4'd7, 4'd7, 13, 1'b0);
        wait_idle(40);
        @(negedge clk);
        total++;
        if ({start_cnt[0], start_cnt[1], start_cnt[2], start_cnt[3]} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
            bad++; $display("FAIL nominal_start_count: got %0d %0d %0d %0d want 1 1 1 1",
                start_cnt[0], start_cnt[1], start_cnt[2], start_cnt[3]);
        end
        total++;
        if ({start_cyc[0], start_cyc[1], start_cyc[2], start_cyc[3]} !== {k + 1, k + 4, k + 7, k + 10}) begin
            bad++; $display("FAIL nominal_start_order: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                start_cyc[0], start_cyc[1], start_cyc[2], start_cyc[3], k + 1, k + 4, k + 7, k + 10);
        end
        total++;
        if ({bus.img_count, bus.correct_count} !== {2'd1, 2'd1}) begin
            bad++; $display("FAIL nominal_counts: got %0d/%0d want 1/1", bus.img_count, bus.correct_count);
        end
        step();
    endtask

    task automatic test_back_to_back();
        test_reset();
        tie_high = 1'b1;
        issue_start(4'd2, 4'd3, 5, 1'b0);
        repeat (4) step();
        issue_start(4'd2, 4'd3, 5, 1'b0);
        wait_idle(30);
        tie_high = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.img_count, bus.correct_count} !== {2'd2, 2'd0}) begin
            bad++; $display("FAIL b2b_counts: got %0d/%0d want 2/0", bus.img_count, bus.correct_count);
        end
        step();
    endtask

    task automatic test_timeout();
        resp_delay = 2;
        stall_pool = 1'b1;
        clr_starts();
        issue_start(4'd5, 4'd5, 4 + TO, 1'b1);
        wait_idle(60);
        stall_pool = 1'b0;
        @(negedge clk);
        total++;
        if ({start_cnt[1], start_cnt[2], start_cnt[3]} !== {32'd1, 32'd0, 32'd0}) begin
            bad++; $display("FAIL timeout_starts: got pool=%0d fc=%0d argmax=%0d want 1 0 0",
                start_cnt[1], start_cnt[2], start_cnt[3]);
        end
        total++;
        if ({bus.timeout, bus.classification} !== {1'b1, 4'hF}) begin
            bad++; $display("FAIL timeout_held: got %b/%h want 1/f", bus.timeout, bus.classification);
        end
        step();
        issue_start(4'd5, 4'd5, 13, 1'b0);
        wait_idle(40);
        // Each done lands exactly in the watchdog's final cycle
        resp_delay = TO - 1;
        issue_start(4'd8, 4'd8, 1 + 4 * TO, 1'b0);
        wait_idle(90);
        resp_delay = 2;
    endtask

    task automatic test_ignored();
        test_reset();
        resp_delay = 2;
        clr_starts();
        issue_start(4'd3, 4'd3, 13, 1'b0);
        force_fc = 1'b1;
        step();
        step();
        force_fc = 1'b0;
        repeat (5) step();
        bus.label = 4'd9;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_idle(40);
        repeat (20) step();
        @(negedge clk);
        total++;
        if ({start_cnt[0], start_cnt[1], start_cnt[2], start_cnt[3]} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
            bad++; $display("FAIL ignored_starts: got %0d %0d %0d %0d want 1 1 1 1",
                start_cnt[0], start_cnt[1], start_cnt[2], start_cnt[3]);
        end
        total++;
        if ({bus.img_count, bus.correct_count} !== {2'd1, 2'd1}) begin
            bad++; $display("FAIL ignored_counts: got %0d/%0d want 1/1", bus.img_count, bus.correct_count);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        resp_delay = 2;
        issue_start(4'd6, 4'd6, 13, 1'b0);
        repeat (4) step();
        rst = 1'b1;
        sb.delete();
        step();
        @(negedge clk);
        total++;
        if ({bus.conv_start, bus.pool_start, bus.fc_start, bus.argmax_start, bus.busy, bus.done} !== 6'b0) begin
            bad++; $display("FAIL midrst_ctrl: got %b want 000000",
                {bus.conv_start, bus.pool_start, bus.fc_start, bus.argmax_start, bus.busy, bus.done});
        end
        total++;
        if ({bus.classification, bus.correct, bus.timeout, bus.img_count, bus.correct_count} !== '0) begin
            bad++; $display("FAIL midrst_outputs: got cls=%h c=%b t=%b img=%0d cor=%0d want all 0",
                bus.classification, bus.correct, bus.timeout, bus.img_count, bus.correct_count);
        end
        step();
        rst = 1'b0;
        clr_starts();
        repeat (10) step();
        total++;
        if ({start_cnt[0], start_cnt[1], start_cnt[2], start_cnt[3]} !== '0) begin
            bad++; $display("FAIL midrst_no_starts: got %0d %0d %0d %0d want 0 0 0 0",
                start_cnt[0], start_cnt[1], start_cnt[2], start_cnt[3]);
        end
        issue_start(4'd6, 4'd6, 13, 1'b0);
        wait_idle(40);
        @(negedge clk);
        total++;
        if (bus.img_count !== 2'd1) begin
            bad++; $display("FAIL midrst_rerun_count: got %0d want 1", bus.img_count);
        end
        step();
    endtask

    task automatic test_stats();
        logic [CW-1:0] exp_n;
        test_reset();
        resp_delay = 0;
        for (int n = 1; n <= 5; n++) begin
            issue_start(4'd4, 4'd4, 5, 1'b0);
            wait_idle(20);
            exp_n = CW'((n > 3) ? 3 : n);
            @(negedge clk);
            total++;
            if ({bus.img_count, bus.correct_count} !== {exp_n, exp_n}) begin
                bad++; $display("FAIL stats_run%0d: got %0d/%0d want %0d/%0d",
                    n, bus.img_count, bus.correct_count, exp_n, exp_n);
            end
            step();
        end
        issue_start(4'd4, 4'd4, 5, 1'b0);
        repeat (4) step();
        bus.clear_stats = 1'b1;
        step();
        bus.clear_stats = 1'b0;
        wait_idle(20);
        @(negedge clk);
        total++;
        if ({bus.img_count, bus.correct_count} !== '0) begin
            bad++; $display("FAIL stats_clear: got %0d/%0d want 0/0", bus.img_count, bus.correct_count);
        end
        total++;
        if ({bus.classification, bus.correct} !== {4'd4, 1'b1}) begin
            bad++; $display("FAIL stats_clear_result: got %h/%b want 4/1", bus.classification, bus.correct);
        end
        step();
    endtask

    task automatic test_label_range();
        resp_delay = 0;
        issue_start(4'hA, 4'h0, 5, 1'b0);
        wait_idle(20);
        issue_start(4'hC, 4'hC, 5, 1'b0);
        wait_idle(20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.label        = 4'h0;
        bus.clear_stats  = 1'b0;
        bus.argmax_class = 4'h0;
        clr_starts();
        test_reset();
        test_nominal();
        test_back_to_back();
        test_timeout();
        test_ignored();
        test_reset_mid_run();
        test_stats();
        test_label_range();
        step();
        total++;
        if (sb.size() !== 0) begin
            bad++; $display("FAIL leftover_results: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cnn_layer_sequencer.md
Name: cnn_layer_sequencer

Overview:
- Control FSM that sequences the CNN inference datapath for one image.
- Stage order: convolution, pooling, fully-connected, argmax. Each stage gets a start pulse, and the block waits for that stage's done before moving on.
- Sits between the top-level start/done interface and the stage engines.
- Latches the ground-truth label, reports classification and correctness, and keeps running image/correct statistics for accuracy measurement.

Parameters:
- TIMEOUT_CYCLES, 4096: max cycles spent in any one stage, counted from the cycle its start pulse is high, before abort.
- CNT_W, 16: width of the image and correct-result statistic counters.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request one inference; honoured only in IDLE.
- label  input  4  ground-truth digit 0-9; sampled on the accepted start.
- clear_stats  input  1  synchronous clear of img_count and correct_count.
- conv_start  output  1  one-cycle start pulse to the conv engine.
- conv_done  input  1  conv engine completion.
- pool_start  output  1  one-cycle start pulse to the pool engine.
- pool_done  input  1  pool engine completion.
- fc_start  output  1  one-cycle start pulse to the FC engine.
- fc_done  input  1  FC engine completion.
- argmax_start  output  1  one-cycle start pulse to the argmax unit.
- argmax_done  input  1  argmax completion.
- argmax_class  input  4  argmax result; valid when argmax_done=1.
- busy  output  1  high while in any stage state.
- done  output  1  one-cycle pulse at end of an inference, normal or aborted.
- classification  output  4  registered predicted digit; held until the next done.
- correct  output  1  classification==latched label; valid and held with classification.
- timeout  output  1  last inference aborted; held until the next done.
- img_count  output  CNT_W  inferences completed, including aborts.
- correct_count  output  CNT_W  inferences with correct=1.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including classification=4'h0, the counters and the latched label.
  - Reset mid-inference abandons the run: no done pulse, and all *_start outputs are low from the next cycle.
- States: IDLE, CONV, POOL, FC, ARGMAX. Each *_start is a registered pulse, high only in the first cycle of its state.
- Stage transitions:
  - IDLE with start=1 at edge N: latch label; state=CONV at N+1 with conv_start=1.
  - In stage state S, S_done=1 is accepted in any cycle of S, including the first (the same cycle as its start pulse).
  - An accepted done advances to the next state on the next edge: CONV->POOL->FC->ARGMAX.
- Completion:
  - ARGMAX with argmax_done=1: latch argmax_class into classification.
  - Set correct=(argmax_class==label_latched) and timeout=0.
  - Next cycle: done=1, state=IDLE.
- Minimum latency: start sampled at cycle 0 gives done at cycle 5; busy=1 in cycles 1-4.
- Back-to-back: a start in the done cycle is accepted; its conv_start follows in the next cycle.
- Start handling: start while busy, or held high continuously, is not queued. A held start re-triggers only in IDLE cycles.
- Stray done inputs in non-matching states are ignored, e.g. fc_done during CONV.
- Timeout:
  - A per-stage counter clears on each stage entry and increments every cycle in the stage.
  - If it reaches TIMEOUT_CYCLES-1 with no done: next cycle done=1, timeout=1, classification=4'hF, correct=0, state=IDLE.
  - The stalled stage's start is not re-issued.
  - A done arriving in that same final cycle wins: normal advance, no timeout.
- Statistics (on every done pulse):
  - img_count+1.
  - correct_count+1 if correct=1.
  - Both counters saturate at all-ones.
  - clear_stats zeroes both counters; if simultaneous with a done, clear wins and both read 0.
  - clear_stats does not affect the FSM or classification.
- Label width: a label above 9 is compared as-is, so a mismatch gives correct=0.

Test Plan:
1. Nominal run: reset, label=7, start pulse; each *_done returned 3 cycles after its start; argmax_class=7 -> start pulses in order, done 13 cycles after start, classification=7, correct=1, img_count=1, correct_count=1.
2. Zero-wait, back-to-back: all dones tied high; start at cycles 0 and 5 with label=2, argmax_class=3 -> done at cycles 5 and 10; correct=0 both times; img_count=2, correct_count=0.
3. Timeout: TIMEOUT_CYCLES=16; pool_done never asserted -> done 16 cycles after pool_start, timeout=1, classification=4'hF, fc_start never pulses; a following normal run clears timeout to 0.
4. Ignored inputs: start pulsed during FC; fc_done asserted during CONV -> no restart, no early advance, exactly one done.
5. Reset mid-run: rst during POOL -> no done, all outputs 0 next cycle; a new start then completes normally.
6. Stats: CNT_W=2, five correct runs -> counts saturate at 3; clear_stats in a done cycle -> both counts read 0 afterwards.
